// File: rtl/io_in_sync_m.sv
// io_in_sync_m: multi-bit input conditioner. Each bit of an asynchronous bus
// is synchronized, debounced, edge-detected, and any change of the debounced
// bus is offered to a consumer as a single-entry valid/ready event with a
// sticky overflow flag when an unaccepted event is overwritten.
module io_in_sync_m #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  synced;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  stable_q, stable_d;
  logic [WIDTH-1:0]                  rise_q, fall_q;
  logic                              valid_q, valid_d;
  logic [WIDTH-1:0]                  data_q, data_d;
  logic                              ovf_q, ovf_d;
  logic                              change;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: stage 0 samples the raw pins, last stage is the synced bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per-bit debounce: count consecutive disagreeing samples, commit on the last one
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (synced[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = synced[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign change = |(stable_d ^ stable_q);

  // Event slot: a new change always wins the slot; overwriting an unaccepted
  // event flags overflow, and that set beats a same-cycle clear
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (change) begin
      valid_d = 1'b1;
      data_d  = stable_d;
      if (valid_q && !out_ready) ovf_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; edge pulses are registered alongside the stable value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign stable    = stable_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_io_in_sync_m.sv
// Directed bench for io_in_sync_m: default-parameter instance plus a
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance.
module tb_io_in_sync_m;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst, out_ready, ovf_clr;
  logic [3:0] in_raw;
  logic [3:0] stable, rise, fall, out_data;
  logic       out_valid, ovf;

  // fast instance
  logic       rst2, out_ready2, ovf_clr2;
  logic [3:0] in_raw2;
  logic [3:0] stable2, rise2, fall2, out_data2;
  logic       out_valid2, ovf2;

  int pass_cnt = 0;
  int total    = 0;

  io_in_sync_m dut (
    .clk(clk), .rst(rst), .in_raw(in_raw), .stable(stable), .rise(rise),
    .fall(fall), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  io_in_sync_m #(.WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst2), .in_raw(in_raw2), .stable(stable2), .rise(rise2),
    .fall(fall2), .out_valid(out_valid2), .out_data(out_data2),
    .out_ready(out_ready2), .ovf(ovf2), .ovf_clr(ovf_clr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_raw = 4'b0000; out_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({stable, rise, fall, out_data, out_valid, ovf} !== 18'd0)
      $display("FAIL reset: stable=%b rise=%b fall=%b data=%b valid=%b ovf=%b, want all 0",
               stable, rise, fall, out_data, out_valid, ovf);
    else pass_cnt++;
  endtask

  // bit0 high for 3 cycles only: nothing must move
  task automatic test_glitch();
    in_raw = 4'b0001;
    tick(); tick(); tick();
    in_raw = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (stable !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || out_valid !== 1'b0)
        $display("FAIL glitch[%0d]: stable=%b rise=%b fall=%b valid=%b, want 0000/0000/0000/0",
                 k, stable, rise, fall, out_valid);
      else pass_cnt++;
    end
  endtask

  // 0000->0101 before edge 0: stable changes after edge 5
  task automatic test_latency();
    in_raw = 4'b0101;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        total++;
        if (stable !== 4'b0000 || out_valid !== 1'b0)
          $display("FAIL latency_early: stable=%b valid=%b, want 0000/0", stable, out_valid);
        else pass_cnt++;
      end
    end
    total++;
    if (stable !== 4'b0101 || rise !== 4'b0101 || out_valid !== 1'b1 || out_data !== 4'b0101)
      $display("FAIL latency: stable=%b rise=%b valid=%b data=%b, want 0101/0101/1/0101",
               stable, rise, out_valid, out_data);
    else pass_cnt++;
    tick();
    total++;
    if (rise !== 4'b0000 || out_valid !== 1'b1 || out_data !== 4'b0101)
      $display("FAIL rise_pulse: rise=%b valid=%b data=%b, want 0000/1/0101",
               rise, out_valid, out_data);
    else pass_cnt++;
  endtask

  task automatic test_overwrite();
    in_raw = 4'b0111;
    for (int k = 0; k <= 5; k++) tick();
    total++;
    if (stable !== 4'b0111 || rise !== 4'b0010 || out_data !== 4'b0111 ||
        out_valid !== 1'b1 || ovf !== 1'b1)
      $display("FAIL overwrite: stable=%b rise=%b data=%b valid=%b ovf=%b, want 0111/0010/0111/1/1",
               stable, rise, out_data, out_valid, ovf);
    else pass_cnt++;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL ovf_clr: ovf=%b valid=%b, want 0/1", ovf, out_valid);
    else pass_cnt++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_data !== 4'b0111)
      $display("FAIL accept: valid=%b data=%b, want 0/0111", out_valid, out_data);
    else pass_cnt++;
    // ready while idle is harmless
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || ovf !== 1'b0)
      $display("FAIL idle_ready: valid=%b ovf=%b, want 0/0", out_valid, ovf);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    in_raw = 4'b0011;
    for (int k = 0; k <= 5; k++) tick();
    total++;
    if (fall !== 4'b0100 || out_valid !== 1'b1 || out_data !== 4'b0011)
      $display("FAIL fall_event: fall=%b valid=%b data=%b, want 0100/1/0011",
               fall, out_valid, out_data);
    else pass_cnt++;
    in_raw = 4'b0001;
    for (int k = 0; k <= 4; k++) tick();
    total++;
    if (stable !== 4'b0011 || out_data !== 4'b0011)
      $display("FAIL hold_data: stable=%b data=%b, want 0011/0011", stable, out_data);
    else pass_cnt++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'b0001 || ovf !== 1'b0)
      $display("FAIL same_edge: valid=%b data=%b ovf=%b, want 1/0001/0",
               out_valid, out_data, ovf);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    in_raw = 4'b0000;
    for (int k = 0; k <= 5; k++) tick();
    in_raw = 4'b1000;
    for (int k = 0; k <= 5; k++) tick();
    total++;
    if (out_valid !== 1'b1 || ovf !== 1'b1 || out_data !== 4'b1000)
      $display("FAIL pre_reset: valid=%b ovf=%b data=%b, want 1/1/1000",
               out_valid, ovf, out_data);
    else pass_cnt++;
    in_raw = 4'b1111;
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({stable, rise, fall, out_data, out_valid, ovf} !== 18'd0)
      $display("FAIL mid_reset: stable=%b rise=%b fall=%b data=%b valid=%b ovf=%b, want all 0",
               stable, rise, fall, out_data, out_valid, ovf);
    else pass_cnt++;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        total++;
        if (stable !== 4'b0000)
          $display("FAIL post_reset_early: stable=%b, want 0000", stable);
        else pass_cnt++;
      end
    end
    total++;
    if (stable !== 4'b1111 || rise !== 4'b1111 || out_valid !== 1'b1 || out_data !== 4'b1111)
      $display("FAIL post_reset: stable=%b rise=%b valid=%b data=%b, want 1111/1111/1/1111",
               stable, rise, out_valid, out_data);
    else pass_cnt++;
  endtask

  task automatic test_fast();
    rst2 = 1'b1; in_raw2 = 4'b0000; out_ready2 = 1'b0; ovf_clr2 = 1'b0;
    tick(); rst2 = 1'b0;
    in_raw2 = 4'b1000;
    for (int k = 0; k <= 3; k++) begin
      tick();
      if (k == 2) begin
        total++;
        if (stable2 !== 4'b0000)
          $display("FAIL fast_early: stable=%b, want 0000", stable2);
        else pass_cnt++;
      end
    end
    total++;
    if (stable2 !== 4'b1000 || rise2 !== 4'b1000 || out_valid2 !== 1'b1)
      $display("FAIL fast_rise: stable=%b rise=%b valid=%b, want 1000/1000/1",
               stable2, rise2, out_valid2);
    else pass_cnt++;
    in_raw2 = 4'b0000;
    for (int k = 0; k <= 3; k++) begin
      tick();
      if (k == 2) begin
        total++;
        if (fall2 !== 4'b0000 || stable2 !== 4'b1000)
          $display("FAIL fast_fall_early: fall=%b stable=%b, want 0000/1000", fall2, stable2);
        else pass_cnt++;
      end
    end
    total++;
    if (fall2 !== 4'b1000 || stable2 !== 4'b0000 || ovf2 !== 1'b1)
      $display("FAIL fast_fall: fall=%b stable=%b ovf=%b, want 1000/0000/1",
               fall2, stable2, ovf2);
    else pass_cnt++;
  endtask

  initial begin
    rst2 = 1'b1; in_raw2 = 4'b0000; out_ready2 = 1'b0; ovf_clr2 = 1'b0;
    test_reset();
    test_glitch();
    test_latency();
    test_overwrite();
    test_back_to_back();
    test_reset_midflight();
    test_fast();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
